// File: rtl/uart16550_tx_path_if.sv
// Bus between the 16550 register block and the transmit path.
// The master drives bytes, FIFO control and line settings; the slave reports line and status.
interface uart16550_tx_path_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          baud_pulse_i;
  logic          tx_push_i;
  logic [7:0]    din_i;
  logic          tx_rst_i;
  logic [7:0]    lcr_i;
  logic          tx_o;
  logic          thre_o;
  logic          temt_o;
  logic          fifo_full_o;
  logic [CW-1:0] fifo_cnt_o;
  logic          overflow_o;

  modport master (
    output baud_pulse_i, tx_push_i, din_i, tx_rst_i, lcr_i,
    input  tx_o, thre_o, temt_o, fifo_full_o, fifo_cnt_o, overflow_o
  );

  modport slave (
    input  baud_pulse_i, tx_push_i, din_i, tx_rst_i, lcr_i,
    output tx_o, thre_o, temt_o, fifo_full_o, fifo_cnt_o, overflow_o
  );
endinterface

// File: rtl/uart16550_tx_path.sv
// Transmit half of a 16550 UART: byte FIFO feeding a framing serializer that advances on baud ticks.
// Line settings are captured when a byte is popped, so LCR writes only affect later frames.
module uart16550_tx_path #(
  parameter int DEPTH = 16,
  parameter int OVS   = 16
) (
  input logic                clk,
  input logic                rst,
  uart16550_tx_path_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(2 * OVS);
  localparam logic [TW-1:0] BIT_LAST    = TW'(OVS - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'((OVS * 3) / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVS - 1);
  localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_overflow;

  state_t        r_state, w_state_n;
  logic [TW-1:0] r_tick, w_tick_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_par, w_par_n;
  logic [3:0]    r_lcr, w_lcr_n;
  logic          r_tx;

  logic          w_empty, w_full, w_push_ok, w_can_start, w_load;
  logic          w_bit_end, w_stop_end, w_par_head, w_line_n, w_unused;
  logic [7:0]    w_head, w_head_masked;
  logic [TW-1:0] w_stop_last;

  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == FULL_CNT);
  assign w_push_ok   = bus.tx_push_i & ~w_full & ~bus.tx_rst_i;
  assign w_can_start = ~w_empty & ~bus.tx_rst_i;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_unused    = bus.lcr_i[7];

  // Parity is computed from the live LCR at pop time, over the transmitted bits only
  assign w_head_masked = w_head & (8'hFF >> (2'd3 - bus.lcr_i[1:0]));
  assign w_par_head    = bus.lcr_i[5] ? ~bus.lcr_i[4] :
                         bus.lcr_i[4] ? ^w_head_masked : ~^w_head_masked;

  assign w_stop_last = ~r_lcr[2]            ? BIT_LAST    :
                       (r_lcr[1:0] == 2'b00) ? STOP15_LAST : STOP2_LAST;
  assign w_bit_end   = (r_tick == BIT_LAST);
  assign w_stop_end  = (r_tick == w_stop_last);

  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_lcr_n   = r_lcr;
    w_load    = 1'b0;
    if (bus.baud_pulse_i) begin
      w_tick_n = r_tick + TW'(1);
      unique case (r_state)
        IDLE: begin
          w_tick_n = '0;
          w_load   = w_can_start;
        end
        START: if (w_bit_end) begin
          w_tick_n  = '0;
          w_bit_n   = '0;
          w_state_n = DATA;
        end
        DATA: if (w_bit_end) begin
          w_tick_n  = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd4 + {1'b0, r_lcr[1:0]})
            w_state_n = r_lcr[3] ? PARITY : STOP;
        end
        PARITY: if (w_bit_end) begin
          w_tick_n  = '0;
          w_state_n = STOP;
        end
        STOP: if (w_stop_end) begin
          w_tick_n  = '0;
          w_state_n = IDLE;
          w_load    = w_can_start;
        end
        default: w_state_n = IDLE;
      endcase
      // Back-to-back frames reload straight from the end of STOP
      if (w_load) begin
        w_state_n = START;
        w_tick_n  = '0;
        w_shift_n = w_head;
        w_lcr_n   = bus.lcr_i[3:0];
        w_par_n   = w_par_head;
      end
    end
  end

  always_comb begin
    w_line_n = 1'b1;
    unique case (w_state_n)
      START:   w_line_n = 1'b0;
      DATA:    w_line_n = w_shift_n[0];
      PARITY:  w_line_n = w_par_n;
      default: w_line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= bus.din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.tx_push_i & w_full & ~bus.tx_rst_i;
      if (bus.tx_rst_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_load)    r_rd_ptr <= r_rd_ptr + AW'(1);
        r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_load);
      end
    end
  end

  // Break masks the line but never holds the FSM, so timing is unaffected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_lcr   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_lcr   <= w_lcr_n;
      r_tx    <= w_line_n & ~bus.lcr_i[6];
    end
  end

  assign bus.tx_o        = r_tx;
  assign bus.thre_o      = w_empty;
  assign bus.temt_o      = w_empty & (r_state == IDLE);
  assign bus.fifo_full_o = w_full;
  assign bus.fifo_cnt_o  = r_cnt;
  assign bus.overflow_o  = r_overflow;
endmodule
